// File: rtl/m_wbuart_pkg.sv
// m_wbuart_pkg: shared state encoding, register selects and status bit positions
package m_wbuart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
   localparam logic REG_DATA   = 1'b0;
   localparam logic REG_STATUS = 1'b1;
   localparam int ST_EMPTY  = 0;
   localparam int ST_FULL   = 1;
   localparam int ST_TXIDLE = 2;
   localparam int ST_OVF    = 3;
   localparam int ST_COUNT  = 8;
endpackage

// File: rtl/m_wbuart_fifo.sv
// m_wbuart_fifo: byte FIFO with first-word fall-through output and occupancy count
module m_wbuart_fifo #(
   parameter int FIFOLOG2 = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic                pop,
   input  logic [7:0]          din,
   output logic [7:0]          dout,
   output logic                empty,
   output logic                full,
   output logic [FIFOLOG2:0]   count
);
   localparam logic [FIFOLOG2:0] DEPTH = {1'b1, {FIFOLOG2{1'b0}}};
   logic [7:0]          mem [2**FIFOLOG2];
   logic [FIFOLOG2-1:0] wptr, rptr;
   assign dout  = mem[rptr];
   assign empty = count == '0;
   assign full  = count == DEPTH;
   // storage has no reset; only the pointers and count define what is valid
   always_ff @(posedge clk)
      if (push) mem[wptr] <= din;
   // pointers wrap naturally at the depth; push and pop together keep count
   always_ff @(posedge clk)
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         count <= count + (FIFOLOG2+1)'(push) - (FIFOLOG2+1)'(pop);
      end
endmodule

// File: rtl/m_wbuart_tx.sv
// m_wbuart_tx: wishbone slave that queues bytes and serialises them as 8N1 on TXD
module m_wbuart_tx
   import m_wbuart_pkg::*;
#(
   parameter int CLKDIV   = 104,
   parameter int FIFOLOG2 = 3
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        STB_I,
   input  logic        WE_I,
   input  logic        ADR_I,
   input  logic [3:0]  SEL_I,
   input  logic [31:0] DAT_I,
   output logic        ACK_O,
   output logic [31:0] DAT_O,
   output logic        TXD,
   output logic        txidle
);
   localparam logic [15:0] RELOAD = 16'(CLKDIV - 1);
   logic              acc, wr_data, rd_status, push, pop, ovf, empty, full, unused;
   logic [7:0]        dout, shreg, shreg_n;
   logic [FIFOLOG2:0] count;
   logic [31:0]       status;
   logic [15:0]       bcnt, bcnt_n;
   logic [2:0]        bidx, bidx_n;
   logic              txd_n, txidle_n;
   tx_state_t         state, state_n;
   assign unused    = ^{SEL_I[3:1], DAT_I[31:8]};
   assign acc       = STB_I & ~ACK_O;
   assign wr_data   = acc & WE_I & (ADR_I == REG_DATA) & SEL_I[0];
   assign rd_status = acc & ~WE_I & (ADR_I == REG_STATUS);
   assign push      = wr_data & (~full | pop);
   m_wbuart_fifo #(.FIFOLOG2(FIFOLOG2)) u_fifo (
      .clk(CLK_I), .rst(RST_I), .push(push), .pop(pop), .din(DAT_I[7:0]),
      .dout(dout), .empty(empty), .full(full), .count(count)
   );
   // status word assembled from live flags
   always_comb begin
      status                          = '0;
      status[ST_EMPTY]                = empty;
      status[ST_FULL]                 = full;
      status[ST_TXIDLE]               = txidle;
      status[ST_OVF]                  = ovf;
      status[ST_COUNT +: FIFOLOG2+1]  = count;
   end
   // bus handshake, read data and the sticky overflow flag
   always_ff @(posedge CLK_I)
      if (RST_I) begin
         ACK_O <= 1'b0;
         DAT_O <= '0;
         ovf   <= 1'b0;
      end else begin
         ACK_O <= acc;
         DAT_O <= rd_status ? status : '0;
         ovf   <= (wr_data & full & ~pop) | (ovf & ~rd_status);
      end
   // serialiser next state: start bit, eight data bits LSB first, stop bit
   always_comb begin
      state_n = state;
      bcnt_n  = (bcnt == '0) ? RELOAD : bcnt - 1'b1;
      bidx_n  = bidx;
      shreg_n = shreg;
      txd_n   = TXD;
      pop     = 1'b0;
      case (state)
         IDLE:
            if (!empty) begin
               pop     = 1'b1;
               shreg_n = dout;
               txd_n   = 1'b0;
               bcnt_n  = RELOAD;
               state_n = START;
            end
         START:
            if (bcnt == '0) begin
               txd_n   = shreg[0];
               bidx_n  = '0;
               state_n = DATA;
            end
         DATA:
            if (bcnt == '0) begin
               if (bidx == 3'd7) begin
                  txd_n   = 1'b1;
                  state_n = STOP;
               end else begin
                  bidx_n = bidx + 3'd1;
                  txd_n  = shreg[bidx + 3'd1];
               end
            end
         STOP:
            if (bcnt == '0) begin
               if (!empty) begin
                  pop     = 1'b1;
                  shreg_n = dout;
                  txd_n   = 1'b0;
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end
         default: state_n = IDLE;
      endcase
      txidle_n = (state_n == IDLE) & empty;
   end
   // serialiser registers; reset aborts any frame in flight
   always_ff @(posedge CLK_I)
      if (RST_I) begin
         state  <= IDLE;
         bcnt   <= '0;
         bidx   <= '0;
         shreg  <= '0;
         TXD    <= 1'b1;
         txidle <= 1'b1;
      end else begin
         state  <= state_n;
         bcnt   <= bcnt_n;
         bidx   <= bidx_n;
         shreg  <= shreg_n;
         TXD    <= txd_n;
         txidle <= txidle_n;
      end
endmodule
